// File: rtl/piano_pkg.sv
// Shared definitions for the free-play keyboard path: FSM states, octave
// codes and the key/octave to note-code mapping used in front of the Buzzer.
package piano_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SOUND,
      ST_SUSTAIN
   } state_t;

   localparam logic [1:0] OCT_LOW  = 2'd0;
   localparam logic [1:0] OCT_MID  = 2'd1;
   localparam logic [1:0] OCT_HIGH = 2'd2;

   localparam int unsigned SILENCE = 0;

   // Octave code 3 is unused on the selector and falls back to mid.
   function automatic logic [1:0] oct_eff(input logic [1:0] oct);
      case (oct)
         OCT_LOW:  return 2'd0;
         OCT_HIGH: return 2'd2;
         default:  return 2'd1;
      endcase
   endfunction

   function automatic logic [7:0] note_code(input logic [3:0] idx,
                                            input logic [1:0] oct,
                                            input logic [4:0] nkeys);
      return 8'd1 + {4'd0, idx} + {3'd0, nkeys} * {6'd0, oct_eff(oct)};
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchroniser, consecutive-mismatch debounce counter and
// registered press/release pulses aligned with the reported level.
module key_debouncer #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0       <= 1'b0;
         sync_p1       <= 1'b0;
         stable        <= 1'b0;
         stable_d      <= 1'b0;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_p0 <= key_raw;
         sync_p1 <= sync_p0;
         // Any cycle where the synchronised input agrees restarts the count.
         if (sync_p1 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= sync_p1;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
         stable_d      <= stable;
         press_pulse   <= stable & ~stable_d;
         release_pulse <= ~stable & stable_d;
      end
   end

   // Level is taken one stage late so it lines up with the event pulses.
   assign level = stable_d;

endmodule

// File: rtl/free_play_ctrl.sv
// Free-play keyboard controller: debounces NUM_KEYS keys, newest press wins,
// applies the octave offset and drives a registered note code, LEDs and busy.
module free_play_ctrl
   import piano_pkg::*;
#(
   parameter int NUM_KEYS       = 7,
   parameter int NOTE_W         = 5,
   parameter int DEB_CYCLES     = 1_000_000,
   parameter int SUSTAIN_CYCLES = 25_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_raw,
   input  logic [1:0]          octave,
   input  logic                sustain_en,
   output logic [NOTE_W-1:0]   note,
   output logic [NUM_KEYS-1:0] led,
   output logic                busy
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
   localparam logic [SW-1:0] SUS_INIT = SW'(SUSTAIN_CYCLES);
   localparam logic [SW-1:0] SUS_LAST = SW'(1);

   logic [NUM_KEYS-1:0] held;
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] rel;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debouncer #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk           (clk),
         .rst           (rst),
         .key_raw       (key_raw[i]),
         .level         (held[i]),
         .press_pulse   (press[i]),
         .release_pulse (rel[i])
      );
   end

   function automatic logic [NOTE_W-1:0] code_of(input logic [KW-1:0] idx,
                                                 input logic [1:0] oct);
      return NOTE_W'(note_code(4'(idx), oct, 5'(NUM_KEYS)));
   endfunction

   function automatic logic [NUM_KEYS-1:0] onehot(input logic [KW-1:0] idx);
      return {{(NUM_KEYS-1){1'b0}}, 1'b1} << idx;
   endfunction

   state_t        state;
   logic [KW-1:0] snd_idx;
   logic [SW-1:0] sus_cnt;

   logic          press_any;
   logic [KW-1:0] press_idx;
   logic          held_any;
   logic [KW-1:0] held_idx;
   logic          take;
   logic [KW-1:0] take_idx;

   // Lowest index wins among simultaneous presses and among held keys.
   always_comb begin
      press_any = 1'b0;
      press_idx = '0;
      held_any  = 1'b0;
      held_idx  = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) begin
            press_any = 1'b1;
            press_idx = KW'(i);
         end
         if (held[i]) begin
            held_any = 1'b1;
            held_idx = KW'(i);
         end
      end
   end

   // A new press always takes over; a released sounding key falls back to a held one.
   always_comb begin
      take     = press_any;
      take_idx = press_idx;
      if (!press_any && state == ST_SOUND && rel[snd_idx] && held_any) begin
         take     = 1'b1;
         take_idx = held_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         snd_idx <= '0;
         sus_cnt <= '0;
         note    <= NOTE_W'(SILENCE);
         led     <= '0;
         busy    <= 1'b0;
      end else if (take) begin
         state   <= ST_SOUND;
         snd_idx <= take_idx;
         sus_cnt <= '0;
         note    <= code_of(take_idx, octave);
         led     <= onehot(take_idx);
         busy    <= 1'b1;
      end else begin
         case (state)
            ST_SOUND: begin
               if (rel[snd_idx]) begin
                  led <= '0;
                  if (sustain_en) begin
                     state   <= ST_SUSTAIN;
                     sus_cnt <= SUS_INIT;
                  end else begin
                     state <= ST_IDLE;
                     note  <= NOTE_W'(SILENCE);
                     busy  <= 1'b0;
                  end
               end
            end
            ST_SUSTAIN: begin
               if (!sustain_en || sus_cnt == SUS_LAST) begin
                  state   <= ST_IDLE;
                  sus_cnt <= '0;
                  note    <= NOTE_W'(SILENCE);
                  busy    <= 1'b0;
               end else begin
                  sus_cnt <= sus_cnt - 1'b1;
               end
            end
            ST_IDLE: begin
               note <= NOTE_W'(SILENCE);
               led  <= '0;
               busy <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               note  <= NOTE_W'(SILENCE);
               led   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/free_play_ctrl.md
# free_play_ctrl

Parametrised free-play keyboard controller: debounces `NUM_KEYS` piano keys, arbitrates between overlapping presses (newest press wins), applies an octave offset, and drives a registered note code plus one-hot key LEDs. It replaces the single-key combinational decoder in front of the existing `Buzzer` block, which consumes `note` unchanged (code 0 = silence). Adds optional sustain: a note rings for a programmable time after release.

## Interface
- `NUM_KEYS`, 7, number of key inputs / LEDs (2..16)
- `NOTE_W`, 5, note code width; must hold `3*NUM_KEYS`
- `DEB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a key level change (≥1)
- `SUSTAIN_CYCLES`, 25_000_000, sustain ring time in clocks (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `key_raw`  in  NUM_KEYS  raw key levels, bit i = key i (key 0 = do), 1 = pressed; asynchronous to `clk`
- `octave`  in  2  0 = low, 1 = mid, 2 = high, 3 treated as mid
- `sustain_en`  in  1  enable sustain after final release
- `note`  out  NOTE_W  registered note code to `Buzzer`; 0 = silent
- `led`  out  NUM_KEYS  registered one-hot of sounding key
- `busy`  out  1  registered; 1 whenever `note != 0`

## Operation
- Per key: 2-flop synchroniser, then debouncer; stable level toggles after sync output differs from stable level for `DEB_CYCLES` consecutive cycles; any mismatch-free cycle resets counter. Press event = stable 0→1 for one cycle; release event = stable 1→0.
- Note code = 1 + key_index + NUM_KEYS × oct_eff; octave latched when a key becomes the sounding key; `octave` changes during a note take effect only at the next key selection.
- FSM states IDLE, SOUND, SUSTAIN:
  - IDLE: note=0, led=0. Any press event → SOUND on the pressed key (lowest index if several in same cycle).
  - SOUND: press event on another key → switch to it (lowest index among simultaneous events). Release of sounding key: other keys still stable-pressed → switch to lowest-index held key; else `sustain_en`=1 → SUSTAIN, counter=SUSTAIN_CYCLES; else IDLE. Release of a non-sounding key: no change.
  - SUSTAIN: note held, led=0, counter decrements each cycle; reaching 0 → IDLE. Press event → SOUND (counter discarded). `sustain_en` deasserted during SUSTAIN → IDLE next cycle.
- Press and release events in same cycle: press handled first (new key sounds).

## Timing
- Reset (async assert): note=0, led=0, busy=0, FSM=IDLE, all debouncer stable levels=0, counters=0. Keys held through reset release re-debounce and produce a fresh press event.
- Latency: key change sampled at edge k, held stable → `note`/`led` update at edge k+DEB_CYCLES+3.
- Glitch shorter than DEB_CYCLES cycles: no output change.
- SUSTAIN lasts exactly SUSTAIN_CYCLES cycles with note≠0, then note=0 at next edge.
- `busy` equals `note != 0` on every cycle; `led` is one-hot or zero, never multi-hot.

## Structure
- Shared package `piano_pkg`: FSM state enum (IDLE/SOUND/SUSTAIN), octave constants, note-code function (index, octave → code), silence code 0.
- Sub-module `key_debouncer` (synchroniser + counter + edge outputs), generated NUM_KEYS times; arbitration/FSM in the top.
- Counter widths via `$clog2(DEB_CYCLES+1)` and `$clog2(SUSTAIN_CYCLES+1)`.

## Test plan
Bench parameters: NUM_KEYS=7, NOTE_W=5, DEB_CYCLES=4, SUSTAIN_CYCLES=8.
- Press key 2, octave=1, hold 20 cycles → note=10, led=0000100 at edge DEB_CYCLES+3; release, sustain_en=0 → note=0 after release debounce.
- 2-cycle glitch on key 5 → note stays 0, led stays 0.
- Hold key 0 (octave 0, note=1), then press key 4 → note=5, led=0010000; release key 4 → note=1 (fallback to held key 0), octave re-latched.
- Keys 3 and 6 pressed same cycle, octave=2 → note=18 (key 3); octave changed to 0 mid-note → note stays 18.
- sustain_en=1, press/release key 1 octave=1 → note=9 for exactly 8 cycles after release event, led=0 during sustain, then note=0; repeat with a key 6 press at sustain cycle 3 → note=14 immediately after its debounce.
- Assert rst mid-SOUND with key held → outputs 0 asynchronously; after release, note reappears DEB_CYCLES+3 edges later.
